inst_cache_loader: RTL and testbench
====================================

Name: inst_cache_loader

Overview:
- Writer side of the instruction cache's debug port.
- Accepts a program image as a valid/ready word stream and writes it into the cache through write_en / debug_addr / debug_input.
- Re-reads every written word through debug_data (1-cycle synchronous read) and compares checksums.
- Used by simulation benches and the boot path to preload programs such as the btb test image.

Parameters:
- DEPTH_W, 12, log2 of cache depth in words (4096 words, word address bits [13:2]).
- CNT_W, 13, width of word count (0..4096 inclusive).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  30  word address [31:2] of first word.
- word_count  in  CNT_W  number of words to load.
- in_valid  in  1  stream word valid.
- in_data  in  32  stream instruction word.
- in_ready  out  1  loader can accept a word.
- write_en  out  1  cache debug write enable.
- debug_addr  out  30  cache debug address [31:2].
- debug_input  out  32  cache debug write data.
- debug_data  in  32  cache debug read data; valid 1 cycle after debug_addr is presented.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of every accepted start.
- error  out  1  sticky result flag; cleared on next accepted start.
- checksum  out  32  sum mod 2^32 of loaded words.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset is async, so write_en drops immediately, including mid-LOAD; no partial state survives.
- States: IDLE, LOAD, VERIFY, CHECK.
- IDLE:
  - On start, latch base_addr, word_count, and clear error and checksum.
  - Range fault when base_addr[31:14]!=0, or base_addr[13:2]+word_count > 4096 (compute 13-bit sum): next cycle error=1, done=1, stay IDLE, no writes.
  - word_count==0: next cycle done=1, error=0, no writes.
  - Otherwise go to LOAD.
- start while busy is ignored.
- LOAD:
  - in_ready=1 while the accepted-word index < word_count.
  - A beat is accepted when in_valid&in_ready.
  - Cycle after each beat (registered outputs): write_en=1, debug_addr=base+idx, debug_input=word, checksum+=word. idx wraps never (range pre-checked).
  - Gaps in in_valid produce write_en=0 cycles; debug_addr holds its last value.
  - After the last beat is accepted, in_ready=0.
  - Cycle after the last write is driven, go to VERIFY.
- VERIFY:
  - write_en=0.
  - debug_addr steps base, base+1, ... one per cycle, word_count addresses.
  - debug_data sampled 1 cycle after each address and summed into a separate readback accumulator. Accumulation is enabled by a 1-cycle delayed valid shift bit.
  - The first read follows the last write by at least one edge, so it sees updated contents.
  - After the last readback is sampled, go to CHECK.
- CHECK (1 cycle): error = (readback sum != checksum). Pulse done. Return to IDLE.
- busy=1 from the cycle after start through the CHECK cycle inclusive.
- Latency for N words with no stream gaps, start edge to done pulse: 2N+3 cycles.
- checksum holds its value in IDLE until the next accepted start.

Decomposition:
- Shared package core_pkg:
  - state enum {IDLE, LOAD, VERIFY, CHECK}.
  - Constant ICACHE_DEPTH_W=12.
  - Constant ICACHE_VALID_HI=18'h0, for the [31:14] range test; the cache and loader must agree on it.
- One natural sub-module: ldr_sum32, a 32-bit accumulator with clear/enable, instantiated twice (write sum, readback sum).

Test Plan:
- Basic load:
  - Stimulus: start, base=0, count=7, words 00000293, 00000313, 06500393, 00530333, 00128293, fe729ce3, 00130313, in_valid held high.
  - Response: 7 consecutive write_en cycles at addr 0..6; done after 17 cycles; error=0; checksum = 32-bit sum of the seven words. The bench cache model then reads the same words.
- Backpressure gaps:
  - Stimulus: same image with in_valid low every other cycle.
  - Response: write_en pattern has gaps, addresses strictly 0..6 in order, identical checksum, error=0.
- Range faults:
  - base=30'h1000 (byte 0x4000), count=1 → done next cycle, error=1, write_en never asserted.
  - base=4090, count=7 → same response.
  - base=4089, count=7 → loads normally.
- Zero count: start with count=0 → done next cycle, error=0, busy pulses at most 1 cycle, no writes.
- Readback mismatch: bench model flips bit 0 of debug_data at addr 3 → error=1 at done; a following clean load clears error to 0.
- Reset mid-LOAD: rst asserted after 3 writes → write_en, busy, in_ready go 0 asynchronously; after release state is IDLE, and a new start loads correctly.

Source files
------------

// File: rtl/inst_cache_loader_pkg.sv
// Shared definitions for the instruction cache and its debug-port loader.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        CHECK
    } ldr_state_e;

    localparam int unsigned ICACHE_DEPTH_W = 12;

    // Upper word-address bits [31:14] that must match for an access to hit the cache.
    localparam logic [17:0] ICACHE_VALID_HI = 18'h0;

endpackage

// File: rtl/inst_cache_loader_sum32.sv
// 32-bit wrapping accumulator with synchronous clear and add enable.
module ldr_sum32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] add_i,
    output logic [31:0] sum_o
);

    logic [31:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (clr_i) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_q + add_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/inst_cache_loader.sv
// Streams a program image into the instruction cache debug port, then reads
// it back and compares the write and readback checksums.
module inst_cache_loader
    import core_pkg::*;
#(
    parameter int unsigned DEPTH_W = ICACHE_DEPTH_W,
    parameter int unsigned CNT_W   = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [29:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             write_en,
    output logic [29:0]      debug_addr,
    output logic [31:0]      debug_input,
    input  logic [31:0]      debug_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      checksum
);

    localparam int unsigned HI_W = 30 - DEPTH_W;
    localparam logic [HI_W-1:0] HI_REF = HI_W'(ICACHE_VALID_HI);
    localparam logic [CNT_W:0]  DEPTH_WORDS = (CNT_W+1)'(1 << DEPTH_W);

    ldr_state_e       state_q, state_d;
    logic [29:0]      base_q, base_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] vidx_q, vidx_d;
    logic             wen_q, wen_d;
    logic [29:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             avld_q, avld_d;
    logic             rvld_q, rvld_d;

    logic             beat;
    logic             sum_clr;
    logic             range_fault;
    logic [CNT_W:0]   end_word;
    logic [31:0]      wsum;
    logic [31:0]      rsum;

    // One bit wider than the count so an oversize count cannot wrap past the check.
    assign end_word    = (CNT_W+1)'(base_addr[DEPTH_W-1:0]) + (CNT_W+1)'(word_count);
    assign range_fault = (base_addr[29:DEPTH_W] != HI_REF) || (end_word > DEPTH_WORDS);

    assign in_ready = (state_q == LOAD) && (idx_q < cnt_q);
    assign beat     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        vidx_d  = vidx_q;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        avld_d  = 1'b0;
        rvld_d  = avld_q;
        sum_clr = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    cnt_d   = word_count;
                    idx_d   = '0;
                    vidx_d  = '0;
                    sum_clr = 1'b1;
                    err_d   = range_fault;
                    if (range_fault || (word_count == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    wen_d   = 1'b1;
                    addr_d  = base_q + 30'(idx_q);
                    wdata_d = in_data;
                    idx_d   = idx_q + CNT_W'(1);
                end else if (idx_q == cnt_q) begin
                    // Last write is on the port this cycle; first read address follows it.
                    state_d = VERIFY;
                    addr_d  = base_q;
                    avld_d  = 1'b1;
                    vidx_d  = CNT_W'(1);
                end
            end
            VERIFY: begin
                if (avld_q && (vidx_q < cnt_q)) begin
                    addr_d = base_q + 30'(vidx_q);
                    vidx_d = vidx_q + CNT_W'(1);
                    avld_d = 1'b1;
                end
                // Final readback word is accumulated on the same edge we leave.
                if (rvld_q && !avld_q) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                done_d  = 1'b1;
                err_d   = (rsum != wsum);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            vidx_q  <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            avld_q  <= 1'b0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            vidx_q  <= vidx_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            avld_q  <= avld_d;
            rvld_q  <= rvld_d;
        end
    end

    ldr_sum32 u_write_sum (
        .clk   (clk),
        .rst   (rst),
        .clr_i (sum_clr),
        .en_i  (beat),
        .add_i (in_data),
        .sum_o (wsum)
    );

    ldr_sum32 u_read_sum (
        .clk   (clk),
        .rst   (rst),
        .clr_i (sum_clr),
        .en_i  (rvld_q),
        .add_i (debug_data),
        .sum_o (rsum)
    );

    assign write_en    = wen_q;
    assign debug_addr  = addr_q;
    assign debug_input = wdata_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign error       = err_q;
    assign checksum    = wsum;

endmodule

// File: tb/tb_inst_cache_loader.sv
// Directed bench for inst_cache_loader with a synchronous-read cache model.
module tb_inst_cache_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [29:0] base_addr = '0;
    logic [12:0] word_count = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        write_en;
    logic [29:0] debug_addr;
    logic [31:0] debug_input;
    logic [31:0] debug_data = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    int errors = 0;
    int checks = 0;
    int flip_addr = -1;

    logic [31:0] mem [4096];
    logic [31:0] img [7];

    typedef struct {
        logic [29:0] base;
        logic [12:0] cnt;
        bit          gap;
        int          flip;
        bit          err;
        int          lat;
        logic [31:0] cs;
        int          nwr;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    inst_cache_loader #(.DEPTH_W(12), .CNT_W(13)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .write_en    (write_en),
        .debug_addr  (debug_addr),
        .debug_input (debug_input),
        .debug_data  (debug_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .checksum    (checksum)
    );

    always @(posedge clk) begin
        if (write_en) mem[debug_addr[11:0]] <= debug_input;
        debug_data <= mem[debug_addr[11:0]] ^
                      ((flip_addr >= 0 && debug_addr == 30'(flip_addr)) ? 32'h1 : 32'h0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int wptr = 0;
        int nwr = 0;
        int gaps = 0;
        int lat = -1;
        bit bad = 0;
        bit saw_busy = 0;
        bit memok = 1;
        flip_addr = v.flip;
        @(negedge clk);
        base_addr  = v.base;
        word_count = v.cnt;
        start      = 1'b1;
        in_valid   = 1'b0;
        @(posedge clk);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) saw_busy = 1;
            if (write_en) begin
                if (debug_addr != v.base + 30'(nwr) || debug_input != img[nwr % 7]) bad = 1;
                nwr++;
            end else if (nwr > 0 && nwr < int'(v.cnt) && !done && busy) begin
                gaps++;
            end
            if (done) begin
                lat = cyc;
                break;
            end
            in_valid = (wptr < int'(v.cnt)) && (!v.gap || (cyc % 2 == 1));
            in_data  = img[wptr % 7];
            if (in_valid && in_ready) wptr++;
        end
        in_valid = 1'b0;
        $display("vector %0d: base=%0d count=%0d latency=%0d", id, v.base, v.cnt, lat);
        chk("done_seen", 32'(lat >= 0), 32'd1);
        if (v.lat >= 0) chk("latency", 32'(lat), 32'(v.lat));
        chk("error_at_done", 32'(error), 32'(v.err));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("checksum", checksum, v.cs);
        chk("write_count", 32'(nwr), 32'(v.nwr));
        chk("write_order", 32'(bad), 32'd0);
        chk("write_gaps", 32'(gaps > 0), 32'(v.gap && v.nwr > 1));
        chk("busy_seen", 32'(saw_busy), 32'(v.nwr > 0));
        for (int k = 0; k < v.nwr; k++)
            if (mem[12'(v.base + 30'(k))] != img[k % 7]) memok = 0;
        chk("cache_contents", 32'(memok), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("error_sticky", 32'(error), 32'(v.err));
        flip_addr = -1;
    endtask

    initial begin
        int wr;
        img[0] = 32'h00000293; img[1] = 32'h00000313; img[2] = 32'h06500393;
        img[3] = 32'h00530333; img[4] = 32'h00128293; img[5] = 32'hfe729ce3;
        img[6] = 32'h00130313;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hdeadbeef;

        //            base     cnt gap flip err lat cs            nwr
        vecs[0] = '{30'd0,    13'd7, 0, -1, 0, 17, 32'h053b2ef5, 7};
        vecs[1] = '{30'd0,    13'd7, 1, -1, 0, -1, 32'h053b2ef5, 7};
        vecs[2] = '{30'h1000, 13'd1, 0, -1, 1, 0,  32'h00000000, 0};
        vecs[3] = '{30'd4090, 13'd7, 0, -1, 1, 0,  32'h00000000, 0};
        vecs[4] = '{30'd4089, 13'd7, 0, -1, 0, 17, 32'h053b2ef5, 7};
        vecs[5] = '{30'd0,    13'd0, 0, -1, 0, 0,  32'h00000000, 0};
        vecs[6] = '{30'd0,    13'd7, 0, 3,  1, 17, 32'h053b2ef5, 7};
        vecs[7] = '{30'd200,  13'd7, 0, -1, 0, 17, 32'h053b2ef5, 7};
        vecs[8] = '{30'd0,    13'd1, 0, -1, 0, 5,  32'h00000293, 1};
        vecs[9] = '{30'd4095, 13'd1, 0, -1, 0, 5,  32'h00000293, 1};

        #12;
        chk("reset_write_en", 32'(write_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done_error", {30'd0, done, error}, 32'd0);
        chk("reset_checksum", checksum, 32'd0);
        chk("reset_addr", 32'(debug_addr), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset asserted mid-LOAD after three writes have been driven.
        @(negedge clk);
        base_addr  = 30'd0;
        word_count = 13'd7;
        start      = 1'b1;
        @(posedge clk);
        wr = 0;
        for (int cyc = 0; cyc < 50 && wr < 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (write_en) wr++;
            in_valid = 1'b1;
            in_data  = img[0];
        end
        chk("midload_writes", 32'(wr), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_write_en", 32'(write_en), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        chk("async_checksum", checksum, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 32'(busy), 32'd0);
        run_vec(10, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
